// File: rtl/instr_mem_loader_pkg.sv
// Shared constants for the instruction-memory loader: memory geometry and
// loader FSM state encodings.
package instr_mem_loader_pkg;

    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_WORDS  = 1024;
    localparam int INST_W      = 32;
    localparam int BYTES_PER_W = INST_W / 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RECV  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Little-endian byte packer: collects up to four bytes into one 32-bit word.
// word_next is the word as it will look once the byte on data_byte is pushed,
// so the top can latch a complete word on the same edge the byte is accepted.
module byte_packer
    import instr_mem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic [7:0]        data_byte,
    output logic [INST_W-1:0] word_next,
    output logic              last_slot
);

    logic [INST_W-1:0] word;
    logic [1:0]        idx;

    // Merge the incoming byte into its lane of the current word.
    always_comb begin
        word_next             = word;
        word_next[idx*8 +: 8] = data_byte;
    end

    assign last_slot = (idx == 2'd3);

    // Word register and byte index; clear wins over push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            idx  <= 2'd0;
        end else if (clr) begin
            word <= '0;
            idx  <= 2'd0;
        end else if (push) begin
            word <= word_next;
            idx  <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: receives a program as a valid/ready byte stream,
// packs it into 32-bit words and writes them to imem from address 0, holding
// the core in reset until the load completes.
//
//   state | meaning
//   IDLE  | after reset, no load in progress, core released
//   RECV  | accepting bytes into the packer
//   WRITE | one-cycle imem write of the packed word
//   DONE  | program loaded, core released
//   ERR   | program exceeded imem capacity, core held
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_W     = IMEM_ADDR_W,
    parameter int DATA_W     = INST_W,
    parameter int IMEM_WORDS = instr_mem_loader_pkg::IMEM_WORDS
) (
    input  logic              ld_in_clk,
    input  logic              ld_in_rst,
    input  logic              ld_in_start,
    input  logic [7:0]        ld_in_byte,
    input  logic              ld_in_valid,
    input  logic              ld_in_last,
    output logic              ld_out_ready,
    output logic [ADDR_W-1:0] ld_out_addr,
    output logic [DATA_W-1:0] ld_out_data,
    output logic              ld_out_wren,
    output logic              ld_out_core_hold,
    output logic              ld_out_done,
    output logic              ld_out_err,
    output logic [ADDR_W:0]   ld_out_count
);

    localparam logic [ADDR_W:0] FINAL_IDX = (ADDR_W+1)'(IMEM_WORDS - 1);

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [ADDR_W:0]   count;
    logic              last_pending;
    logic              accept;
    logic              start_go;
    logic              pk_clr;
    logic              pk_last_slot;
    logic [DATA_W-1:0] pk_word_next;

    assign ld_out_ready = (state == ST_RECV);
    assign accept       = ld_in_valid && ld_out_ready;
    assign start_go     = ld_in_start &&
                          ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign pk_clr       = start_go || (state == ST_WRITE);
    assign ld_out_count = count;

    byte_packer u_packer (
        .clk       (ld_in_clk),
        .rst_n     (ld_in_rst),
        .clr       (pk_clr),
        .push      (accept),
        .data_byte (ld_in_byte),
        .word_next (pk_word_next),
        .last_slot (pk_last_slot)
    );

    // Next-state decode; a final word that exactly fills memory still ends in DONE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (ld_in_start) state_next = ST_RECV;
            end
            ST_RECV: begin
                if (accept && (pk_last_slot || ld_in_last)) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (last_pending)         state_next = ST_DONE;
                else if (count == FINAL_IDX) state_next = ST_ERR;
                else                      state_next = ST_RECV;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, word counter and last-byte flag.
    always_ff @(posedge ld_in_clk or negedge ld_in_rst) begin
        if (!ld_in_rst) begin
            state        <= ST_IDLE;
            count        <= '0;
            last_pending <= 1'b0;
        end else begin
            state <= state_next;
            if (start_go) begin
                count        <= '0;
                last_pending <= 1'b0;
            end else begin
                if (state == ST_WRITE) count <= count + 1'b1;
                if (accept && ld_in_last) last_pending <= 1'b1;
            end
        end
    end

    // Registered outputs, driven from the state being entered so they line up with it.
    always_ff @(posedge ld_in_clk or negedge ld_in_rst) begin
        if (!ld_in_rst) begin
            ld_out_wren      <= 1'b0;
            ld_out_addr      <= '0;
            ld_out_data      <= '0;
            ld_out_core_hold <= 1'b0;
            ld_out_done      <= 1'b0;
            ld_out_err       <= 1'b0;
        end else begin
            ld_out_wren      <= (state_next == ST_WRITE);
            ld_out_core_hold <= (state_next == ST_RECV) || (state_next == ST_WRITE) ||
                                (state_next == ST_ERR);
            ld_out_done      <= (state_next == ST_DONE);
            ld_out_err       <= (state_next == ST_ERR);
            if ((state == ST_RECV) && (state_next == ST_WRITE)) begin
                ld_out_addr <= count[ADDR_W-1:0];
                ld_out_data <= pk_word_next;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed programs plus random ones, checked
// against a word-level packing model of the byte stream.
module tb_instr_mem_loader;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic        valid     = 1'b0;
    logic        last      = 1'b0;
    logic [7:0]  data_byte = 8'h00;
    logic        ready;
    logic [9:0]  addr;
    logic [31:0] data;
    logic        wren;
    logic        hold;
    logic        done;
    logic        err;
    logic [10:0] count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  prog_q[$];
    logic [31:0] exp_data_q[$];
    int          exp_addr_q[$];
    int          exp_words;

    always #5 clk = ~clk;

    instr_mem_loader dut (
        .ld_in_clk        (clk),
        .ld_in_rst        (rst_n),
        .ld_in_start      (start),
        .ld_in_byte       (data_byte),
        .ld_in_valid      (valid),
        .ld_in_last       (last),
        .ld_out_ready     (ready),
        .ld_out_addr      (addr),
        .ld_out_data      (data),
        .ld_out_wren      (wren),
        .ld_out_core_hold (hold),
        .ld_out_done      (done),
        .ld_out_err       (err),
        .ld_out_count     (count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every imem write must match the next word the model predicts.
    always @(negedge clk) begin
        if (wren === 1'b1) begin
            if (exp_data_q.size() == 0) begin
                check("unexpected_wren", 64'd1, 64'd0);
            end else begin
                check("wr_addr", 64'(addr), 64'(exp_addr_q.pop_front()));
                check("wr_data", 64'(data), 64'(exp_data_q.pop_front()));
                check("ready_in_write", 64'(ready), 64'd0);
            end
        end
    end

    // Model: bytes fill words little-endian; a word closes on its 4th byte or the
    // last byte; at most 1024 words fit.
    task automatic build_expected(input bit with_last);
        logic [31:0] w;
        w = 32'h0;
        exp_words = 0;
        exp_data_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < prog_q.size(); i++) begin
            if (exp_words == 1024) break;
            w = w | (32'(prog_q[i]) << (8 * (i % 4)));
            if ((i % 4 == 3) || (with_last && i == prog_q.size() - 1)) begin
                exp_data_q.push_back(w);
                exp_addr_q.push_back(exp_words);
                exp_words++;
                w = 32'h0;
            end
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Send prog_q[first .. first+cnt-1]; optional 3-cycle stall before byte stall_idx.
    task automatic send_bytes(input int first, input int cnt, input bit with_last,
                              input int stall_idx, input bit rnd);
        int c;
        for (int i = first; i < first + cnt; i++) begin
            if (i == stall_idx) begin
                valid = 1'b0;
                repeat (3) @(negedge clk);
            end
            if (rnd && $urandom_range(0, 3) == 0) begin
                valid = 1'b0;
                @(negedge clk);
            end
            data_byte = prog_q[i];
            last      = with_last && (i == prog_q.size() - 1);
            valid     = 1'b1;
            c = 0;
            while (ready !== 1'b1 && c < 20) begin
                @(negedge clk);
                c++;
            end
            if (ready !== 1'b1) begin
                check("accept_timeout", 64'd0, 64'd1);
                valid = 1'b0;
                last  = 1'b0;
                return;
            end
            @(negedge clk);
            valid = 1'b0;
            last  = 1'b0;
        end
    endtask

    task automatic wait_end(input string tag);
        int c = 0;
        while (!(done === 1'b1 || err === 1'b1) && c < 40) begin
            @(negedge clk);
            c++;
        end
        if (!(done === 1'b1 || err === 1'b1)) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic check_finished(input string tag, input int words);
        wait_end(tag);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_hold"}, 64'(hold), 64'd0);
        check({tag, "_count"}, 64'(count), 64'(words));
        check({tag, "_all_written"}, 64'(exp_data_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(ready), 64'd0);
        check({tag, "_wren"}, 64'(wren), 64'd0);
        check({tag, "_addr"}, 64'(addr), 64'd0);
        check({tag, "_data"}, 64'(data), 64'd0);
        check({tag, "_hold"}, 64'(hold), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_count"}, 64'(count), 64'd0);
    endtask

    initial begin
        int n;

        // Reset state
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 64'(ready), 64'd0);

        // Single word 0x00010820
        prog_q = '{8'h20, 8'h08, 8'h01, 8'h00};
        build_expected(1'b1);
        do_start();
        check("t1_hold_recv", 64'(hold), 64'd1);
        check("t1_ready_recv", 64'(ready), 64'd1);
        check("t1_count_clr", 64'(count), 64'd0);
        send_bytes(0, 4, 1'b1, -1, 1'b0);
        check_finished("t1", 1);

        // Two words with a 3-cycle valid stall mid-word
        prog_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        build_expected(1'b1);
        do_start();
        send_bytes(0, 8, 1'b1, 2, 1'b0);
        check_finished("t2", 2);

        // Zero-padded final word
        prog_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        build_expected(1'b1);
        do_start();
        send_bytes(0, 6, 1'b1, -1, 1'b0);
        check_finished("t3", 2);
        check("t3_pad_data", 64'(data), 64'h0000FFEE);

        // Random programs with random source stalls
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 40);
            prog_q.delete();
            for (int i = 0; i < n; i++) prog_q.push_back(8'($urandom));
            build_expected(1'b1);
            do_start();
            send_bytes(0, n, 1'b1, -1, 1'b1);
            check_finished("rand", (n + 3) / 4);
        end

        // Program exactly filling memory ends in DONE, not ERR
        prog_q.delete();
        for (int i = 0; i < 4096; i++) prog_q.push_back(8'($urandom));
        build_expected(1'b1);
        do_start();
        send_bytes(0, 4096, 1'b1, -1, 1'b1);
        check_finished("full", 1024);

        // Overflow: no last within capacity
        for (int i = 0; i < 4096; i++) prog_q[i] = 8'($urandom);
        prog_q.push_back(8'h5A);
        build_expected(1'b0);
        do_start();
        send_bytes(0, 4096, 1'b0, -1, 1'b1);
        wait_end("ovf");
        check("ovf_err", 64'(err), 64'd1);
        check("ovf_done", 64'(done), 64'd0);
        check("ovf_hold", 64'(hold), 64'd1);
        check("ovf_count", 64'(count), 64'd1024);
        check("ovf_all_written", 64'(exp_data_q.size()), 64'd0);
        data_byte = 8'h5A;
        valid     = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("ovf_ready_low", 64'(ready), 64'd0);
        end
        valid = 1'b0;
        check("ovf_count_held", 64'(count), 64'd1024);
        do_start();
        check("restart_count", 64'(count), 64'd0);
        check("restart_err", 64'(err), 64'd0);
        check("restart_ready", 64'(ready), 64'd1);
        check("restart_hold", 64'(hold), 64'd1);

        // Asynchronous reset mid-load after one word
        prog_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        build_expected(1'b1);
        send_bytes(0, 5, 1'b1, -1, 1'b0);
        check("rst_one_word_written", 64'(exp_data_q.size()), 64'd1);
        exp_data_q.delete();
        exp_addr_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle_ready", 64'(ready), 64'd0);

        // Start pulse during RECV is ignored
        prog_q = '{8'h9C, 8'h3D, 8'h47, 8'hE1};
        build_expected(1'b1);
        do_start();
        send_bytes(0, 2, 1'b1, -1, 1'b0);
        do_start();
        check("ign_ready", 64'(ready), 64'd1);
        send_bytes(2, 2, 1'b1, -1, 1'b0);
        check_finished("ign", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
